// File: rtl/medidor_pkg.sv
// Shared types and defaults for the gated frequency counter.
//   estadoT : gate FSM state
//   clog2   : bits needed to hold values 0..value-1
package medidor_pkg;

  localparam int unsigned CLOCK_HZ            = 50_000_000;
  localparam int unsigned DEFAULT_GATE_CYCLES = CLOCK_HZ;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 27;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } estadoT;

  // Smallest width whose range covers 0..value-1 (at least 1 bit).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (((value - 32'd1) >> i) != 32'd0) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/medidor_frequencia_sincronizador_borda.sv
// Synchronizes an asynchronous input and emits a one-cycle pulse per rising edge.
//   clock       : system clock
//   reset       : synchronous active-low reset
//   asyncSignal : asynchronous input
//   edgePulse   : registered rising-edge pulse, SYNC_STAGES+1 cycles after the input rises
module sincronizador_borda
  import medidor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic asyncSignal,
  output logic edgePulse
);

  logic [SYNC_STAGES-1:0] syncChain;
  logic                   prevSample;

  // Metastability chain, previous-value register and registered edge detect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      syncChain  <= '0;
      prevSample <= 1'b0;
      edgePulse  <= 1'b0;
    end else begin
      syncChain  <= {syncChain[SYNC_STAGES-2:0], asyncSignal};
      prevSample <= syncChain[SYNC_STAGES-1];
      edgePulse  <= syncChain[SYNC_STAGES-1] & ~prevSample;
    end
  end

endmodule

// File: rtl/medidor_frequencia.sv
// Gated frequency counter: counts rising edges of signalIn over GATE_CYCLES clocks.
//   clock     : system clock
//   reset     : synchronous active-low reset
//   enable    : 1 = measure, 0 = halt and discard the current window
//   signalIn  : asynchronous signal to measure
//   frequency : edge count of the last completed window
//   valid     : one-cycle pulse when frequency updates
//   overflow  : last completed window saturated the edge counter
//   busy      : high while a window is in progress
module medidor_frequencia
  import medidor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   signalIn,
  output logic [COUNT_WIDTH-1:0] frequency,
  output logic                   valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned            GATE_WIDTH = clog2(GATE_CYCLES);
  localparam logic [GATE_WIDTH-1:0]  LAST_GATE  = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT  = '1;

  estadoT                 state, nextState;
  logic [GATE_WIDTH-1:0]  gateCount, gateNext;
  logic [COUNT_WIDTH-1:0] edgeCount, edgeNext;
  logic                   satFlag, satNext;
  logic [COUNT_WIDTH-1:0] frequencyNext;
  logic                   overflowNext, validNext, busyNext;
  logic                   edgePulse;
  logic [COUNT_WIDTH-1:0] countWithEdge;
  logic                   satWithEdge;

  sincronizador_borda #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSincronizador (
    .clock      (clock),
    .reset      (reset),
    .asyncSignal(signalIn),
    .edgePulse  (edgePulse)
  );

  // Edge counter and saturation flag as they stand including this cycle's edge.
  always_comb begin
    countWithEdge = edgeCount;
    satWithEdge   = satFlag;
    if (edgePulse) begin
      if (edgeCount == MAX_COUNT) satWithEdge = 1'b1;
      else countWithEdge = edgeCount + COUNT_WIDTH'(1);
    end
  end

  // Next-state and datapath: disable is checked before the window-end capture.
  always_comb begin
    nextState     = state;
    gateNext      = gateCount;
    edgeNext      = edgeCount;
    satNext       = satFlag;
    frequencyNext = frequency;
    overflowNext  = overflow;
    validNext     = 1'b0;
    unique case (state)
      IDLE: begin
        gateNext = '0;
        edgeNext = '0;
        satNext  = 1'b0;
        if (enable) nextState = GATE;
      end
      GATE: begin
        if (!enable) begin
          nextState = IDLE;
          gateNext  = '0;
          edgeNext  = '0;
          satNext   = 1'b0;
        end else if (gateCount == LAST_GATE) begin
          frequencyNext = countWithEdge;
          overflowNext  = satWithEdge;
          validNext     = 1'b1;
          gateNext      = '0;
          edgeNext      = '0;
          satNext       = 1'b0;
        end else begin
          gateNext = gateCount + GATE_WIDTH'(1);
          edgeNext = countWithEdge;
          satNext  = satWithEdge;
        end
      end
      default: nextState = IDLE;
    endcase
    busyNext = (nextState == GATE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      gateCount <= '0;
      edgeCount <= '0;
      satFlag   <= 1'b0;
      frequency <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nextState;
      gateCount <= gateNext;
      edgeCount <= edgeNext;
      satFlag   <= satNext;
      frequency <= frequencyNext;
      overflow  <= overflowNext;
      valid     <= validNext;
      busy      <= busyNext;
    end
  end

endmodule
